c_collect: RTL



---
 rtl/c_collect.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/c_collect.sv
// Collects the serial 16-bit result stream into a full MxM matrix and offers it as one flat bus.
// Optional idle-timeout abort of partial matrices is enabled by defining COLLECT_TIMEOUT_EN.
module c_collect #(
    parameter int unsigned M       = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic                       vld_in,
    input  logic [15:0]                c_in,
    output logic                       rdy_in,
    output logic [16*M*M-1:0]          c_mat,
    output logic                       vld_out,
    input  logic                       rdy_out,
    output logic [$clog2(M*M+1)-1:0]   count,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int unsigned DW = 16;
    localparam int unsigned NW = M * M;
    localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned CW = $clog2(NW + 1);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [RW-1:0]   row_q;
    logic [RW-1:0]   col_q;
    logic [31:0]     wr_idx_c;
    logic            col_end_c;
    logic            row_end_c;
    logic            accept_c;
    logic            last_c;
    logic            release_c;
    logic            timeout_hit_c;

    assign col_end_c = (col_q == RW'(M - 1));
    assign row_end_c = (row_q == RW'(M - 1));
    assign wr_idx_c  = 32'(row_q) * M + 32'(col_q);

    // Handshake flags are pure decodes of the state register.
    assign rdy_in  = (state_q == ST_COLLECT);
    assign vld_out = (state_q == ST_HOLD);

    // State register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        release_c = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (vld_in) begin
                    accept_c = 1'b1;
                    if (row_end_c && col_end_c) begin
                        last_c  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (rdy_out) begin
                    release_c = 1'b1;
                    state_d   = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // Position counters, word count and matrix storage.
    always_ff @(posedge CLK) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            count <= '0;
            c_mat <= '0;
        end else if (accept_c) begin
            for (int unsigned e = 0; e < NW; e++) begin
                if (wr_idx_c == e) begin
                    c_mat[DW*(NW-1-e) +: DW] <= c_in;
                end
            end
            count <= count + CW'(1);
            if (last_c) begin
                row_q <= '0;
                col_q <= '0;
            end else if (col_end_c) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + RW'(1);
            end
        end else if (release_c || timeout_hit_c) begin
            // Stale c_mat entries are kept; only the position is rewound.
            row_q <= '0;
            col_q <= '0;
            count <= '0;
        end
    end

    // Sticky flag for words offered while the matrix is being held.
    always_ff @(posedge CLK) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (vld_in && !rdy_in) begin
            overrun <= 1'b1;
        end
    end

`ifdef COLLECT_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] idle_q;

    assign timeout_hit_c = (state_q == ST_COLLECT) && !vld_in && (count != '0)
                         && (idle_q == IW'(TIMEOUT - 1));

    // Idle counter only runs on a partially filled matrix.
    always_ff @(posedge CLK) begin
        if (rst) begin
            idle_q      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit_c;
            if ((state_q != ST_COLLECT) || accept_c || timeout_hit_c) begin
                idle_q <= '0;
            end else if (count != '0) begin
                idle_q <= idle_q + IW'(1);
            end
        end
    end
`else
    // Without the timeout a partial matrix waits indefinitely.
    localparam bit TIMEOUT_NONZERO = (TIMEOUT != 0);

    assign timeout_hit_c = 1'b0;
    assign timeout_err   = 1'b0 & TIMEOUT_NONZERO;
`endif

endmodule
